baud_tick_gen: RTL and testbench

Parametrised, runtime-programmable clock-enable generator for the UART link between the two FPGAs. It divides the board clock into a 16x oversample tick, a mid-bit sample strobe and a 1x baud tick. It supports divisor reload without glitches and receiver phase resynchronisation. The UART TX and RX FSMs sit downstream and consume its single-cycle strobes; no logic is clocked by any derived clock.

---
 rtl/baud_tick_if.sv | 25 ++
 rtl/baud_tick_gen.sv | 95 +++++++++
 tb/tb_baud_tick_gen.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/baud_tick_if.sv
// Control/strobe bundle between baud_tick_gen and the UART TX/RX FSMs.
// outClock is only driven with a live square wave when BAUD_CLKOUT_EN is defined.
interface baud_tick_if #(
    parameter int DIV_W = 16
);
    logic             enable;
    logic             divLoad;
    logic [DIV_W-1:0] divValue;
    logic             resync;
    logic             divPending;
    logic             tick16;
    logic             midBit;
    logic             tickBaud;
    logic             outClock;

    modport master (
        output enable, divLoad, divValue, resync,
        input  divPending, tick16, midBit, tickBaud, outClock
    );

    modport slave (
        input  enable, divLoad, divValue, resync,
        output divPending, tick16, midBit, tickBaud, outClock
    );
endinterface

// File: rtl/baud_tick_gen.sv
// UART clock-enable generator: 16x oversample tick, mid-bit strobe and baud tick.
// Optional debug square wave on outClock is built only when BAUD_CLKOUT_EN is defined.
module baud_tick_gen #(
    parameter int DIV_W      = 16,
    parameter int RESET_DIV  = 163,
    parameter int OVERSAMPLE = 16
) (
    input logic        inClock,
    input logic        reset,
    baud_tick_if.slave bus
);
    localparam int              OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

    logic [DIV_W-1:0] preCnt;
    logic [DIV_W-1:0] activeDiv;
    logic [DIV_W-1:0] shadowDiv;
    logic [DIV_W-1:0] lastCnt;
    logic [OS_W-1:0]  osCnt;
    logic             preWrap;
    logic             divPending;
    logic             tick16;
    logic             midBit;
    logic             tickBaud;

    // Divisor 0 behaves as 1. The >= compare keeps a divisor shrunk while
    // disabled from letting preCnt run past the new terminal count.
    assign lastCnt = (activeDiv == '0) ? '0 : activeDiv - 1'b1;
    assign preWrap = (preCnt >= lastCnt);

    always_ff @(posedge inClock) begin
        if (reset) begin
            preCnt     <= '0;
            osCnt      <= '0;
            activeDiv  <= DIV_W'(RESET_DIV);
            shadowDiv  <= DIV_W'(RESET_DIV);
            divPending <= 1'b0;
            tick16     <= 1'b0;
            midBit     <= 1'b0;
            tickBaud   <= 1'b0;
        end else begin
            tick16   <= 1'b0;
            midBit   <= 1'b0;
            tickBaud <= 1'b0;
            if (bus.resync) begin
                preCnt     <= '0;
                osCnt      <= '0;
                activeDiv  <= shadowDiv;
                divPending <= 1'b0;
            end else if (!bus.enable) begin
                activeDiv  <= shadowDiv;
                divPending <= 1'b0;
            end else if (preWrap) begin
                preCnt     <= '0;
                osCnt      <= (osCnt == OS_LAST) ? '0 : osCnt + 1'b1;
                tick16     <= 1'b1;
                midBit     <= (osCnt == OS_MID);
                tickBaud   <= (osCnt == OS_LAST);
                activeDiv  <= shadowDiv;
                divPending <= 1'b0;
            end else begin
                preCnt <= preCnt + 1'b1;
            end
            // A capture on an applying edge keeps the new value pending.
            if (bus.divLoad) begin
                shadowDiv  <= bus.divValue;
                divPending <= 1'b1;
            end
        end
    end

    assign bus.divPending = divPending;
    assign bus.tick16     = tick16;
    assign bus.midBit     = midBit;
    assign bus.tickBaud   = tickBaud;

`ifdef BAUD_CLKOUT_EN
    logic outClk;

    always_ff @(posedge inClock) begin
        if (reset) begin
            outClk <= 1'b0;
        end else if (bus.resync) begin
            outClk <= 1'b0;
        end else if (bus.enable && preWrap && (osCnt == OS_LAST)) begin
            outClk <= ~outClk;
        end
    end

    assign bus.outClock = outClk;
`else
    assign bus.outClock = 1'b0;
`endif
endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen; outClock expectations follow BAUD_CLKOUT_EN.
module tb_baud_tick_gen;
    logic inClock = 1'b0;
    logic reset;
    int   testsRun = 0;
    int   testsFailed = 0;
    int   edgeNum = 0;

    baud_tick_if #(.DIV_W(16)) bus();

    baud_tick_gen #(.DIV_W(16), .RESET_DIV(163), .OVERSAMPLE(16)) dut (
        .inClock (inClock),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #20 inClock = ~inClock;

    task automatic step();
        @(posedge inClock);
        #1;
        edgeNum++;
    endtask

    task automatic resetDut();
        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.divLoad  = 1'b0;
        bus.divValue = '0;
        bus.resync   = 1'b0;
        repeat (2) step();
        reset   = 1'b0;
        edgeNum = 0;
    endtask

    // Capture and apply a divisor while disabled (applied on the second edge).
    task automatic loadDisabled(input logic [15:0] v);
        bus.divValue = v;
        bus.divLoad  = 1'b1;
        step();
        bus.divLoad  = 1'b0;
        step();
        edgeNum = 0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.enable   = 1'b1;
        bus.divLoad  = 1'b0;
        bus.divValue = '0;
        bus.resync   = 1'b0;
        repeat (3) step();
        testsRun++; if (bus.tick16 !== 1'b0) begin testsFailed++; $display("FAIL reset_tick16: got %b expected 0", bus.tick16); end
        testsRun++; if (bus.midBit !== 1'b0) begin testsFailed++; $display("FAIL reset_midBit: got %b expected 0", bus.midBit); end
        testsRun++; if (bus.tickBaud !== 1'b0) begin testsFailed++; $display("FAIL reset_tickBaud: got %b expected 0", bus.tickBaud); end
        testsRun++; if (bus.divPending !== 1'b0) begin testsFailed++; $display("FAIL reset_divPending: got %b expected 0", bus.divPending); end
        testsRun++; if (bus.outClock !== 1'b0) begin testsFailed++; $display("FAIL reset_outClock: got %b expected 0", bus.outClock); end
    endtask

    task automatic test_default();
        int t16First = 0, t16Second = 0, t16Count = 0, midFirst = 0, baudFirst = 0, baudSecond = 0;
        resetDut();
        bus.enable = 1'b1;
        for (int i = 0; i < 5216; i++) begin
            step();
            if (bus.tick16 === 1'b1) begin
                t16Count++;
                if (t16First == 0) t16First = edgeNum;
                else if (t16Second == 0) t16Second = edgeNum;
            end
            if (bus.midBit === 1'b1 && midFirst == 0) midFirst = edgeNum;
            if (bus.tickBaud === 1'b1) begin
                if (baudFirst == 0) baudFirst = edgeNum;
                else if (baudSecond == 0) baudSecond = edgeNum;
            end
        end
        testsRun++; if (t16First != 163) begin testsFailed++; $display("FAIL default_t16_first: got %0d expected 163", t16First); end
        testsRun++; if (t16Second != 326) begin testsFailed++; $display("FAIL default_t16_second: got %0d expected 326", t16Second); end
        testsRun++; if (t16Count != 32) begin testsFailed++; $display("FAIL default_t16_count: got %0d expected 32", t16Count); end
        testsRun++; if (midFirst != 1304) begin testsFailed++; $display("FAIL default_mid_first: got %0d expected 1304", midFirst); end
        testsRun++; if (baudFirst != 2608) begin testsFailed++; $display("FAIL default_baud_first: got %0d expected 2608", baudFirst); end
        testsRun++; if (baudSecond != 5216) begin testsFailed++; $display("FAIL default_baud_second: got %0d expected 5216", baudSecond); end
    endtask

    task automatic test_reload();
        int ticks[3] = '{0, 0, 0};
        int n = 0;
        resetDut();
        bus.enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            bus.divLoad  = (edgeNum == 49);
            bus.divValue = 16'd10;
            step();
            if (bus.tick16 === 1'b1 && n < 3) begin ticks[n] = edgeNum; n++; end
            if (edgeNum == 50) begin testsRun++; if (bus.divPending !== 1'b1) begin testsFailed++; $display("FAIL reload_pending_set: got %b expected 1", bus.divPending); end end
            if (edgeNum == 162) begin testsRun++; if (bus.divPending !== 1'b1) begin testsFailed++; $display("FAIL reload_pending_hold: got %b expected 1", bus.divPending); end end
            if (edgeNum == 163) begin testsRun++; if (bus.divPending !== 1'b0) begin testsFailed++; $display("FAIL reload_pending_clear: got %b expected 0", bus.divPending); end end
        end
        bus.divLoad = 1'b0;
        testsRun++; if (ticks[0] != 163) begin testsFailed++; $display("FAIL reload_old_period: got %0d expected 163", ticks[0]); end
        testsRun++; if (ticks[1] != 173) begin testsFailed++; $display("FAIL reload_new_period1: got %0d expected 173", ticks[1]); end
        testsRun++; if (ticks[2] != 183) begin testsFailed++; $display("FAIL reload_new_period2: got %0d expected 183", ticks[2]); end
    endtask

    task automatic test_back_to_back();
        int ticks[2] = '{0, 0};
        int n = 0;
        resetDut();
        bus.enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            bus.divLoad  = (edgeNum == 4) || (edgeNum == 5);
            bus.divValue = (edgeNum == 4) ? 16'd7 : 16'd12;
            step();
            if (bus.tick16 === 1'b1 && n < 2) begin ticks[n] = edgeNum; n++; end
            if (edgeNum == 6) begin testsRun++; if (bus.divPending !== 1'b1) begin testsFailed++; $display("FAIL b2b_pending: got %b expected 1", bus.divPending); end end
        end
        bus.divLoad = 1'b0;
        testsRun++; if (ticks[0] != 163) begin testsFailed++; $display("FAIL b2b_old_period: got %0d expected 163", ticks[0]); end
        testsRun++; if (ticks[1] != 175) begin testsFailed++; $display("FAIL b2b_last_wins: got %0d expected 175", ticks[1]); end
    endtask

    task automatic test_resync();
        int preCount = 0, t16After = 0, midAfter = 0, baudAfter = 0;
        resetDut();
        loadDisabled(16'd10);
        bus.enable = 1'b1;
        for (int i = 0; i < 250; i++) begin
            bus.resync = (edgeNum == 79);
            step();
            if (edgeNum < 80 && bus.tick16 === 1'b1) preCount++;
            if (edgeNum == 80) begin
                testsRun++; if (bus.tick16 !== 1'b0) begin testsFailed++; $display("FAIL resync_no_tick16: got %b expected 0", bus.tick16); end
                testsRun++; if (bus.midBit !== 1'b0) begin testsFailed++; $display("FAIL resync_no_midBit: got %b expected 0", bus.midBit); end
            end
            if (edgeNum > 80) begin
                if (bus.tick16 === 1'b1 && t16After == 0) t16After = edgeNum;
                if (bus.midBit === 1'b1 && midAfter == 0) midAfter = edgeNum;
                if (bus.tickBaud === 1'b1 && baudAfter == 0) baudAfter = edgeNum;
            end
        end
        bus.resync = 1'b0;
        testsRun++; if (preCount != 7) begin testsFailed++; $display("FAIL resync_pre_ticks: got %0d expected 7", preCount); end
        testsRun++; if (t16After != 90) begin testsFailed++; $display("FAIL resync_next_tick16: got %0d expected 90", t16After); end
        testsRun++; if (midAfter != 160) begin testsFailed++; $display("FAIL resync_next_midBit: got %0d expected 160", midAfter); end
        testsRun++; if (baudAfter != 240) begin testsFailed++; $display("FAIL resync_next_tickBaud: got %0d expected 240", baudAfter); end
    endtask

    task automatic test_div_zero_one();
        for (int v = 0; v < 2; v++) begin
            int t16Count = 0, midFirst = 0, midCount = 0, baudFirst = 0, baudCount = 0;
            resetDut();
            loadDisabled(16'(v));
            bus.enable = 1'b1;
            for (int i = 0; i < 40; i++) begin
                step();
                if (bus.tick16 === 1'b1) t16Count++;
                if (bus.midBit === 1'b1) begin midCount++; if (midFirst == 0) midFirst = edgeNum; end
                if (bus.tickBaud === 1'b1) begin baudCount++; if (baudFirst == 0) baudFirst = edgeNum; end
            end
            testsRun++; if (t16Count != 40) begin testsFailed++; $display("FAIL div%0d_t16_count: got %0d expected 40", v, t16Count); end
            testsRun++; if (midFirst != 8) begin testsFailed++; $display("FAIL div%0d_mid_first: got %0d expected 8", v, midFirst); end
            testsRun++; if (midCount != 3) begin testsFailed++; $display("FAIL div%0d_mid_count: got %0d expected 3", v, midCount); end
            testsRun++; if (baudFirst != 16) begin testsFailed++; $display("FAIL div%0d_baud_first: got %0d expected 16", v, baudFirst); end
            testsRun++; if (baudCount != 2) begin testsFailed++; $display("FAIL div%0d_baud_count: got %0d expected 2", v, baudCount); end
        end
    endtask

    task automatic test_enable_gap();
        int strobes = 0, firstTick = 0;
        resetDut();
        loadDisabled(16'd20);
        bus.enable = 1'b1;
        repeat (12) begin
            step();
            if (bus.tick16 === 1'b1) strobes++;
        end
        bus.enable = 1'b0;
        repeat (30) begin
            step();
            if (bus.tick16 === 1'b1 || bus.midBit === 1'b1 || bus.tickBaud === 1'b1) strobes++;
        end
        bus.enable = 1'b1;
        edgeNum = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.tick16 === 1'b1 && firstTick == 0) firstTick = edgeNum;
        end
        testsRun++; if (strobes != 0) begin testsFailed++; $display("FAIL gap_strobes: got %0d expected 0", strobes); end
        testsRun++; if (firstTick != 8) begin testsFailed++; $display("FAIL gap_next_tick16: got %0d expected 8", firstTick); end
    endtask

    task automatic test_outclock();
        resetDut();
        loadDisabled(16'd4);
        bus.enable = 1'b1;
`ifdef BAUD_CLKOUT_EN
        for (int i = 0; i < 200; i++) begin
            logic expOut;
            bus.resync = (edgeNum == 192);
            step();
            expOut = 1'bx;
            case (edgeNum)
                63:  expOut = 1'b0;
                64:  expOut = 1'b1;
                127: expOut = 1'b1;
                128: expOut = 1'b0;
                192: expOut = 1'b1;
                193: expOut = 1'b0;
                default: expOut = 1'bx;
            endcase
            if (expOut !== 1'bx) begin
                testsRun++;
                if (bus.outClock !== expOut) begin testsFailed++; $display("FAIL outclock_edge%0d: got %b expected %b", edgeNum, bus.outClock, expOut); end
            end
        end
        bus.resync = 1'b0;
`else
        begin
            int highSeen = 0;
            for (int i = 0; i < 200; i++) begin
                step();
                if (bus.outClock !== 1'b0) highSeen++;
            end
            testsRun++; if (highSeen != 0) begin testsFailed++; $display("FAIL outclock_tied_low: got %0d non-zero cycles expected 0", highSeen); end
        end
`endif
    endtask

    task automatic test_reset_mid();
        int firstTick = 0;
        resetDut();
        bus.enable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus.divLoad  = (edgeNum == 19);
            bus.divValue = 16'd10;
            step();
        end
        bus.divLoad = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        testsRun++; if (bus.divPending !== 1'b0) begin testsFailed++; $display("FAIL rstmid_pending: got %b expected 0", bus.divPending); end
        edgeNum = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.tick16 === 1'b1 && firstTick == 0) firstTick = edgeNum;
        end
        testsRun++; if (firstTick != 163) begin testsFailed++; $display("FAIL rstmid_first_tick16: got %0d expected 163", firstTick); end
    endtask

    initial begin
        test_reset();
        test_default();
        test_reload();
        test_back_to_back();
        test_resync();
        test_div_zero_one();
        test_enable_gap();
        test_outclock();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
